// File: rtl/sha256_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : sha256_uart_pkg
// Brief  : Shared constants, state encodings and hex decode helper for the
//          UART SHA-256 host.
// Rev    : 1.0  initial release
// ============================================================================
package sha256_uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_SEND_START   = 3'd1;
  localparam state_t ST_SEND_PAYLOAD = 3'd2;
  localparam state_t ST_SEND_TERM    = 3'd3;
  localparam state_t ST_RECV         = 3'd4;
  localparam state_t ST_DONE         = 3'd5;

  localparam logic [7:0] FRAME_START  = 8'h01;
  localparam logic [7:0] FRAME_END    = 8'hFF;
  localparam int         DIGEST_CHARS = 64;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_nibble_t;

  // Letters share the low nibble pattern 1..6 in both cases, hence the +9.
  function automatic hex_nibble_t hex_to_nibble(input logic [7:0] i_char);
    hex_nibble_t r_res;
    r_res = '{valid: 1'b0, nibble: 4'h0};
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      r_res = '{valid: 1'b1, nibble: i_char[3:0]};
    end else if ((i_char >= 8'h61 && i_char <= 8'h66) ||
                 (i_char >= 8'h41 && i_char <= 8'h46)) begin
      r_res = '{valid: 1'b1, nibble: i_char[3:0] + 4'd9};
    end
    return r_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module : hex_ascii_decoder
// Brief  : Combinational ASCII hex character to nibble decoder with valid flag.
// Rev    : 1.0  initial release
// ============================================================================
module hex_ascii_decoder
  import sha256_uart_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  hex_nibble_t w_dec;

  assign w_dec    = hex_to_nibble(i_char);
  assign o_nibble = w_dec.nibble;
  assign o_valid  = w_dec.valid;

endmodule
`default_nettype wire

// File: rtl/sha256_uart_host.sv
`default_nettype none
// ============================================================================
// Module : sha256_uart_host
// Brief  : Frames a message as 01/payload/FF over UART TX and decodes the
//          64-char hex digest returned on UART RX. Optional RX inactivity
//          timeout enabled by defining SHA_HOST_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module sha256_uart_host
  import sha256_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   i_msg_data,
  input  logic         i_msg_valid,
  input  logic         i_msg_last,
  output logic         o_msg_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_data_valid,
  input  logic         i_tx_data_ready,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_data_valid,
  output logic         o_rx_data_ready,
  output logic [255:0] o_digest,
  output logic         o_digest_valid,
  output logic         o_busy,
  output logic         o_error
);

  state_t       r_state;
  logic [7:0]   r_tx_data;
  logic         r_tx_valid;
  logic         r_last;
  logic [255:0] r_digest;
  logic         r_digest_valid;
  logic         r_error;
  logic [5:0]   r_nib_cnt;

  logic         w_tx_accept;
  logic         w_msg_accept;
  logic [3:0]   w_rx_nibble;
  logic         w_rx_hex;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("sha256_uart_host: TIMEOUT_CYCLES must be non-zero");
  end

`ifdef SHA_HOST_TIMEOUT_EN
  logic [31:0] r_tmo;
`endif

  hex_ascii_decoder u_hex_dec (
    .i_char  (i_rx_data),
    .o_nibble(w_rx_nibble),
    .o_valid (w_rx_hex)
  );

  assign w_tx_accept  = r_tx_valid && i_tx_data_ready;
  assign w_msg_accept = i_msg_valid && o_msg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_tx_data      <= 8'h00;
      r_tx_valid     <= 1'b0;
      r_last         <= 1'b0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_error        <= 1'b0;
      r_nib_cnt      <= 6'd0;
`ifdef SHA_HOST_TIMEOUT_EN
      r_tmo          <= 32'd0;
`endif
    end else begin
      r_digest_valid <= 1'b0;
      r_error        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_msg_valid) begin
            r_tx_data  <= FRAME_START;
            r_tx_valid <= 1'b1;
            r_state    <= ST_SEND_START;
          end
        end
        ST_SEND_START: begin
          if (w_tx_accept) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_SEND_PAYLOAD;
          end
        end
        ST_SEND_PAYLOAD: begin
          if (w_tx_accept) begin
            if (r_last) begin
              r_last    <= 1'b0;
              r_tx_data <= FRAME_END;
              r_state   <= ST_SEND_TERM;
            end else begin
              r_tx_valid <= 1'b0;
            end
          end else if (w_msg_accept) begin
            // 0xFF would be mistaken for the terminator, so it is dropped.
            if (i_msg_data == FRAME_END) begin
              r_error <= 1'b1;
              if (i_msg_last) begin
                r_tx_data  <= FRAME_END;
                r_tx_valid <= 1'b1;
                r_state    <= ST_SEND_TERM;
              end
            end else begin
              r_tx_data  <= i_msg_data;
              r_tx_valid <= 1'b1;
              r_last     <= i_msg_last;
            end
          end
        end
        ST_SEND_TERM: begin
          if (w_tx_accept) begin
            r_tx_valid <= 1'b0;
            r_digest   <= '0;
            r_nib_cnt  <= 6'd0;
            r_state    <= ST_RECV;
`ifdef SHA_HOST_TIMEOUT_EN
            r_tmo      <= 32'd0;
`endif
          end
        end
        ST_RECV: begin
          if (i_rx_data_valid) begin
`ifdef SHA_HOST_TIMEOUT_EN
            r_tmo <= 32'd0;
`endif
            if (w_rx_hex) begin
              r_digest  <= {r_digest[251:0], w_rx_nibble};
              r_nib_cnt <= r_nib_cnt + 6'd1;
              if (r_nib_cnt == 6'(DIGEST_CHARS - 1)) begin
                r_state <= ST_DONE;
              end
            end else begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
`ifdef SHA_HOST_TIMEOUT_EN
          else if (r_tmo == TIMEOUT_CYCLES) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
`endif
        end
        ST_DONE: begin
          r_digest_valid <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_msg_ready     = (r_state == ST_SEND_PAYLOAD) && !r_tx_valid;
  assign o_tx_data       = r_tx_data;
  assign o_tx_data_valid = r_tx_valid;
  assign o_rx_data_ready = 1'b1;
  assign o_digest        = r_digest;
  assign o_digest_valid  = r_digest_valid;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sha256_uart_host.sv
`default_nettype none
// ============================================================================
// Module : tb_sha256_uart_host
// Brief  : Scoreboard bench for sha256_uart_host: TX bytes and digests are
//          queued at stimulus time and compared when the DUT produces them.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sha256_uart_host;

  localparam int unsigned TB_TIMEOUT = 100;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   msg_data = 8'h00;
  logic         msg_valid = 1'b0;
  logic         msg_last = 1'b0;
  logic         tx_ready = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         o_msg_ready, o_tx_data_valid, o_rx_data_ready;
  logic         o_digest_valid, o_busy, o_error;
  logic [7:0]   o_tx_data;
  logic [255:0] o_digest;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int n_dv = 0;
  int n_err = 0;
  int ready_mode = 0;
  logic [7:0]   exp_tx_q[$];
  logic [255:0] exp_dg_q[$];
  logic [7:0]   msg[$];

  sha256_uart_host #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_msg_data     (msg_data),
    .i_msg_valid    (msg_valid),
    .i_msg_last     (msg_last),
    .o_msg_ready    (o_msg_ready),
    .o_tx_data      (o_tx_data),
    .o_tx_data_valid(o_tx_data_valid),
    .i_tx_data_ready(tx_ready),
    .i_rx_data      (rx_data),
    .i_rx_data_valid(rx_valid),
    .o_rx_data_ready(o_rx_data_ready),
    .o_digest       (o_digest),
    .o_digest_valid (o_digest_valid),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_tx_data_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) check_eq("tx_unexpected", {248'b0, o_tx_data}, 256'h100);
        else check_eq("tx_byte", o_tx_data, exp_tx_q.pop_front());
      end
      if (o_error) n_err++;
      if (o_digest_valid) begin
        n_dv++;
        if (exp_dg_q.size() == 0) check_eq("dv_unexpected", 1, 0);
        else begin
          check_eq("digest", o_digest, exp_dg_q.pop_front());
          check_eq("dv_latency", cyc - last_rx_cyc, 2);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_msg_ready", o_msg_ready, 0);
    check_eq("rst_tx_data", o_tx_data, 0);
    check_eq("rst_tx_valid", o_tx_data_valid, 0);
    check_eq("rst_digest", o_digest, 0);
    check_eq("rst_dv", o_digest_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_error", o_error, 0);
    check_eq("rx_ready", o_rx_data_ready, 1);
  endtask

  task automatic drive_msg(input logic [7:0] b[$]);
    bit ok;
    for (int i = 0; i < b.size(); i++) begin
      msg_data  = b[i];
      msg_last  = (i == b.size() - 1);
      msg_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (o_msg_ready) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
      if (!ok) check_eq("msg_accept_timeout", 0, 1);
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    exp_tx_q.push_back(8'h01);
    foreach (b[i]) if (b[i] != 8'hFF) exp_tx_q.push_back(b[i]);
    exp_tx_q.push_back(8'hFF);
    drive_msg(b);
    for (int t = 0; t < 2000; t++) begin
      if (exp_tx_q.size() == 0) break;
      @(posedge clk);
    end
    check_eq("tx_drain", exp_tx_q.size(), 0);
    wait_cycles(2);
  endtask

  task automatic feed_digest(input logic [255:0] d, input bit upper, input int n_chars, input int bad_at);
    logic [3:0] nib;
    logic [7:0] c;
    if (n_chars == 64 && bad_at < 0) exp_dg_q.push_back(d);
    for (int i = 0; i < n_chars; i++) begin
      nib = d[255 - 4*i -: 4];
      if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
      else c = (upper ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
      if (i == bad_at) c = 8'h67;
      rx_data     = c;
      rx_valid    = 1'b1;
      last_rx_cyc = cyc;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      if (i == bad_at) begin
        @(negedge clk);
        check_eq("bad_err", o_error, 1);
        check_eq("bad_busy", o_busy, 0);
        check_eq("bad_partial", o_digest, d >> (256 - 4*bad_at));
        wait_cycles(1);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int dv0, err0;

  initial begin
    wait_cycles(4);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);

    // lowercase digest, TX always ready
    dv0 = n_dv; err0 = n_err;
    msg = {8'h61, 8'h62, 8'h63};
    send_frame(msg);
    check_eq("busy_recv", o_busy, 1);
    feed_digest(ABC_DIGEST, 1'b0, 64, -1);
    wait_cycles(4);
    check_eq("t1_dv_count", n_dv - dv0, 1);
    check_eq("t1_err_count", n_err - err0, 0);
    check_eq("t1_busy", o_busy, 0);
    check_eq("t1_digest_held", o_digest, ABC_DIGEST);

    // uppercase digest, TX ready toggling
    dv0 = n_dv;
    ready_mode = 1;
    send_frame(msg);
    ready_mode = 0;
    feed_digest(ABC_DIGEST, 1'b1, 64, -1);
    wait_cycles(4);
    check_eq("t2_dv_count", n_dv - dv0, 1);

    // illegal hex char as 11th character
    dv0 = n_dv; err0 = n_err;
    send_frame(msg);
    feed_digest(ABC_DIGEST, 1'b0, 64, 10);
    wait_cycles(4);
    check_eq("t3_dv_count", n_dv - dv0, 0);
    check_eq("t3_err_count", n_err - err0, 1);

    // 0xFF inside the payload is dropped
    dv0 = n_dv; err0 = n_err;
    msg = {8'h41, 8'hFF, 8'h42};
    send_frame(msg);
    check_eq("t4_err_count", n_err - err0, 1);
    feed_digest(ABC_DIGEST, 1'b0, 64, -1);
    wait_cycles(4);
    check_eq("t4_dv_count", n_dv - dv0, 1);

    // 0xFF as the final payload byte still gets a terminator
    err0 = n_err;
    msg = {8'h41, 8'hFF};
    send_frame(msg);
    check_eq("t5_err_count", n_err - err0, 1);
    feed_digest(ABC_DIGEST, 1'b0, 64, 0);
    wait_cycles(2);

    // RX stalls after 30 characters
    dv0 = n_dv; err0 = n_err;
    msg = {8'h61, 8'h62, 8'h63};
    send_frame(msg);
    feed_digest(ABC_DIGEST, 1'b0, 30, -1);
    wait_cycles(1000);
`ifdef SHA_HOST_TIMEOUT_EN
    check_eq("t6_tmo_err", n_err - err0, 1);
    check_eq("t6_tmo_busy", o_busy, 0);
`else
    check_eq("t6_err_count", n_err - err0, 0);
    check_eq("t6_still_busy", o_busy, 1);
`endif
    check_eq("t6_dv_count", n_dv - dv0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);

    // reset while a payload byte is stuck in TX
    exp_tx_q.push_back(8'h01);
    exp_tx_q.push_back(8'h61);
    msg = {8'h61};
    msg_data = 8'h61;
    msg_last = 1'b0;
    msg_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_msg_ready) break;
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    ready_mode = 2;
    wait_cycles(3);
    @(negedge clk);
    check_eq("t7_tx_data", o_tx_data, 8'h61);
    check_eq("t7_tx_valid", o_tx_data_valid, 1);
    check_eq("t7_msg_ready", o_msg_ready, 0);
    check_eq("t7_busy", o_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals();
    exp_tx_q.delete();
    ready_mode = 0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);

    dv0 = n_dv;
    msg = {8'h61, 8'h62, 8'h63};
    send_frame(msg);
    feed_digest(ABC_DIGEST, 1'b0, 64, -1);
    wait_cycles(4);
    check_eq("t8_dv_count", n_dv - dv0, 1);
    check_eq("dg_queue_empty", exp_dg_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_uart_host.md
# sha256_uart_host

Host-side initiator for the UART SHA-256 byte protocol. Takes a message as a byte stream, frames it as `0x01`, payload, `0xFF` on a byte-level UART TX handshake, then collects the 64 lowercase/uppercase ASCII hex characters returned on the UART RX handshake and decodes them into a 256-bit digest. It sits between a local message source and an instance pair of `uart_tx`/`uart_rx`, and drives the hashing responder on the far end of the serial link.

## Interface
- `TIMEOUT_CYCLES`, default 27_000_000: RX inter-character timeout in `clk` cycles; used only with `SHA_HOST_TIMEOUT_EN`.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `msg_data`  in  8  message byte.
- `msg_valid`  in  1  `msg_data` valid.
- `msg_last`  in  1  marks final message byte; qualified by `msg_valid`.
- `msg_ready`  out  1  byte accepted when `msg_valid && msg_ready`.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_valid`  out  1  held until accepted.
- `tx_data_ready`  in  1  from `uart_tx`; byte accepted when `tx_data_valid && tx_data_ready`.
- `rx_data`  in  8  byte from `uart_rx`.
- `rx_data_valid`  in  1  one-cycle strobe per received byte.
- `rx_data_ready`  out  1  constant 1.
- `digest`  out  256  decoded hash; first character received is `digest[255:252]`.
- `digest_valid`  out  1  one-cycle pulse.
- `busy`  out  1  high in every state except IDLE.
- `error`  out  1  one-cycle pulse on any protocol fault.

## Operation
- Reset values: `msg_ready`=0, `tx_data`=0, `tx_data_valid`=0, `digest`=0, `digest_valid`=0, `busy`=0, `error`=0. State is IDLE and all counters are 0.
- States: IDLE, SEND_START, SEND_PAYLOAD, SEND_TERM, RECV, DONE.
- IDLE: `msg_ready`=0. When `msg_valid` is seen, load `tx_data`=`0x01` and set `tx_data_valid`, then go to SEND_START. `digest` keeps its previous value until RECV begins.
- SEND_START: when the start byte is accepted, go to SEND_PAYLOAD.
- SEND_PAYLOAD: `msg_ready` = `!tx_data_valid`. An accepted byte is loaded into `tx_data` and `tx_data_valid` is set. If the accepted byte has `msg_last` set, record it; when that byte is accepted by TX, load `0xFF` and go to SEND_TERM.
- Payload byte equal to `0xFF`: the byte is accepted, not transmitted, and pulses `error`. The frame continues. If that byte carried `msg_last`, the terminator is still sent.
- SEND_TERM: when `0xFF` is accepted, clear `digest` and the nibble counter (6 bits), then go to RECV.
- RECV: on each `rx_data_valid`:
  - `'0'`-`'9'`, `'a'`-`'f'` and `'A'`-`'F'` are decoded. `digest` ← {`digest[251:0]`, nibble} and the counter increments.
  - On the 64th character, go to DONE.
  - Any other byte pulses `error`, aborts to IDLE, and leaves `digest` partial with no `digest_valid`.
- DONE: pulse `digest_valid` for one cycle, then return to IDLE.
- RX bytes outside RECV are discarded silently.
- Simultaneous `msg_valid` in DONE is ignored until IDLE.
- Reset mid-frame returns to the reset values immediately. An in-flight UART byte is the UART core's concern.

## Timing
- `tx_data`/`tx_data_valid` are registered. A new TX byte is presented the cycle after the previous one is accepted, so the block sustains at most 1 byte per 2 cycles. This is far above the UART rate.
- `digest_valid` rises 2 cycles after the 64th `rx_data_valid` (capture cycle, then DONE). `digest` is stable from the DONE cycle onward.
- `error` is registered and rises 1 cycle after the offending strobe or accept.
- `busy` rises the cycle after IDLE sees `msg_valid` and falls the cycle after DONE or an abort.

## Configuration
- `SHA_HOST_TIMEOUT_EN` defined: a 32-bit counter runs in RECV. It resets on entry and on every `rx_data_valid`. When it reaches `TIMEOUT_CYCLES`, the block pulses `error` and returns to IDLE.
- Undefined: no counter is built and RECV waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `sha256_uart_pkg`:
  - State enum.
  - Constants `FRAME_START`=`8'h01`, `FRAME_END`=`8'hFF`, `DIGEST_CHARS`=64.
  - Function `hex_to_nibble` returning {valid, nibble[3:0]}.
- Sub-module `hex_ascii_decoder`: combinational ASCII→nibble+valid, instantiated once in RECV datapath.

## Test plan
- Message "abc" (`61 62 63`, last on `63`), `tx_data_ready` always 1 → TX sequence `01 61 62 63 FF`. Then feed RX "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad" → `digest`=`256'hba7816bf…15ad` and `digest_valid` is a single pulse 2 cycles after the last char.
- Same digest sent in uppercase with `tx_data_ready` toggling randomly → identical TX bytes, no byte dropped or duplicated, same `digest`.
- Char `'g'` (`0x67`) as 11th RX char → `error` pulse, no `digest_valid`, `busy`=0 next cycle.
- Payload `41 FF 42` (last on `42`) → TX `01 41 42 FF`, exactly one `error` pulse.
- With `SHA_HOST_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, stop RX after 30 chars → `error` after 100 idle cycles, state IDLE. Without the macro → still `busy` after 1000 cycles.
- `rst_n` low during SEND_PAYLOAD and again mid-RECV → all outputs at reset values. A following "abc" frame completes correctly.
